// File: rtl/glitcbus_master.sv
// GLITCBUS byte-wide multiplexed bus initiator (TISC side).
// Define GLITCBUS_MASTER_DEBUG_EN to drive debug_o; otherwise it is tied to 0.
module glitcbus_master #(
  parameter int RD_WAIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        GSEL_B,
  output logic        GRDWR_B,
  output logic [7:0]  gad_o,
  input  logic [7:0]  gad_i,
  output logic        gad_oe_o,
  output logic [70:0] debug_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, WDATA, RWAIT, RDATA, GAP
  } state_t;

  localparam logic [3:0] WLAST = 4'(RD_WAIT - 1);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] sh_q;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        take;
  logic        sel_d, rdwr_d, oe_d;
  logic [7:0]  gad_d;

  assign cmd_ready_o = (state_q == IDLE) & ~rst_i;
  assign take        = cmd_valid_i & cmd_ready_o;
  assign wr_d        = take ? cmd_wr_i : wr_q;
  assign addr_d      = take ? cmd_addr_i : addr_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE:   if (take) state_d = ADDR_H;
      ADDR_H: state_d = ADDR_L;
      ADDR_L: begin
        bcnt_d  = 2'd0;
        wcnt_d  = 4'd0;
        state_d = wr_q ? WDATA : RWAIT;
      end
      WDATA: begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = GAP;
      end
      RWAIT: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == WLAST) begin
          state_d = RDATA;
          bcnt_d  = 2'd0;
        end
      end
      RDATA: begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered, so they are decoded from the next state
  always_comb begin
    sel_d  = 1'b1;
    rdwr_d = 1'b1;
    oe_d   = 1'b0;
    gad_d  = 8'h00;
    unique case (state_d)
      ADDR_H: begin
        sel_d  = 1'b0;
        rdwr_d = ~wr_d;
        oe_d   = 1'b1;
        gad_d  = addr_d[15:8];
      end
      ADDR_L: begin
        sel_d  = 1'b0;
        rdwr_d = ~wr_d;
        oe_d   = 1'b1;
        gad_d  = addr_d[7:0];
      end
      WDATA: begin
        sel_d  = 1'b0;
        rdwr_d = ~wr_d;
        oe_d   = 1'b1;
        gad_d  = sh_q[31:24];
      end
      RWAIT, RDATA: begin
        sel_d  = 1'b0;
        rdwr_d = ~wr_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      sh_q        <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      GSEL_B      <= 1'b1;
      GRDWR_B     <= 1'b1;
      gad_o       <= '0;
      gad_oe_o    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      GSEL_B      <= sel_d;
      GRDWR_B     <= rdwr_d;
      gad_o       <= gad_d;
      gad_oe_o    <= oe_d;
      rsp_valid_o <= (state_d == GAP);
      // One register shifts write bytes out and read bytes in
      if (take)
        sh_q <= cmd_dat_i;
      else if (state_d == WDATA)
        sh_q <= {sh_q[23:0], 8'h00};
      else if (state_q == RDATA)
        sh_q <= {sh_q[23:0], gad_i};
      if (state_d == GAP)
        rsp_dat_o <= (state_q == RDATA) ? {sh_q[23:0], gad_i} : 32'h0;
    end
  end

`ifdef GLITCBUS_MASTER_DEBUG_EN
  assign debug_o = {rsp_valid_o, sh_q, addr_q, gad_i, gad_o,
                    gad_oe_o, GRDWR_B, GSEL_B, state_q};
`else
  assign debug_o = '0;
`endif

endmodule

// File: tb/tb_glitcbus_master.sv
// Directed bench for glitcbus_master: writes, reads, back-to-back,
// input capture, mid-frame reset and maximum read wait.
module tb_glitcbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_valid2;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_dat;
  logic [7:0]  gad_i, gad_i2;
  logic        ready, ready2;
  logic        rsp_valid, rsp_valid2;
  logic [31:0] rsp_dat, rsp_dat2;
  logic        gsel, gsel2, grdwr, grdwr2, oe, oe2;
  logic [7:0]  gad, gad2;
  logic [70:0] dbg, dbg2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  glitcbus_master #(.RD_WAIT(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(ready),
    .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat),
    .GSEL_B(gsel), .GRDWR_B(grdwr),
    .gad_o(gad), .gad_i(gad_i), .gad_oe_o(oe),
    .debug_o(dbg)
  );

  glitcbus_master #(.RD_WAIT(15)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(ready2),
    .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid2), .rsp_dat_o(rsp_dat2),
    .GSEL_B(gsel2), .GRDWR_B(grdwr2),
    .gad_o(gad2), .gad_i(gad_i2), .gad_oe_o(oe2),
    .debug_o(dbg2)
  );

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [70:0] obs,
                     input logic [70:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [7:0] wbytes [6];
  int n;

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_valid2 = 0; cmd_wr = 0;
    cmd_addr = 0; cmd_dat = 0; gad_i = 0; gad_i2 = 0;
    nx(); nx();
    chk("rst_gsel", gsel, 1);
    chk("rst_grdwr", grdwr, 1);
    chk("rst_gad", gad, 0);
    chk("rst_oe", oe, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_dat, 0);
    chk("rst_ready", ready, 0);
    chk("debug_off", dbg, 0);
    rst = 1'b0;
    #1;
    chk("idle_ready", ready, 1);

    // write 0x0042 <- 0xDEADBEEF
    wbytes = '{8'h00, 8'h42, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0042; cmd_dat = 32'hDEADBEEF;
    nx();
    cmd_valid = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr_gad%0d", i), gad, wbytes[i]);
      chk($sformatf("wr_sel%0d", i), gsel, 0);
      chk($sformatf("wr_rdwr%0d", i), grdwr, 0);
      chk($sformatf("wr_oe%0d", i), oe, 1);
      chk($sformatf("wr_rspv%0d", i), rsp_valid, 0);
      nx();
    end
    chk("wr_rspv", rsp_valid, 1);
    chk("wr_rspd", rsp_dat, 0);
    chk("wr_gap_sel", gsel, 1);
    chk("wr_gap_ready", ready, 0);
    nx();
    chk("wr_idle_ready", ready, 1);
    chk("wr_rspv_off", rsp_valid, 0);

    // read 0x0010, RD_WAIT=2
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 16'h0010;
    nx();
    cmd_valid = 0;
    chk("rd_gad0", gad, 8'h00);
    chk("rd_rdwr", grdwr, 1);
    chk("rd_oe0", oe, 1);
    nx();
    chk("rd_gad1", gad, 8'h10);
    nx();
    chk("rd_oe_n3", oe, 0);
    chk("rd_sel_n3", gsel, 0);
    nx();
    chk("rd_oe_n4", oe, 0);
    nx(); gad_i = 8'h12;
    chk("rd_oe_n5", oe, 0);
    nx(); gad_i = 8'h34;
    nx(); gad_i = 8'h56;
    nx(); gad_i = 8'h78;
    chk("rd_sel_n8", gsel, 0);
    chk("rd_rspv_n8", rsp_valid, 0);
    nx(); gad_i = 8'h00;
    chk("rd_rspv", rsp_valid, 1);
    chk("rd_rspd", rsp_dat, 32'h12345678);
    chk("rd_gap_sel", gsel, 1);
    nx();

    // reset in N+4 of a read
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 16'h0020;
    nx();
    cmd_valid = 0;
    nx(); nx(); nx();
    rst = 1;
    nx();
    chk("rr_sel", gsel, 1);
    chk("rr_oe", oe, 0);
    chk("rr_rspv", rsp_valid, 0);
    chk("rr_rspd", rsp_dat, 0);
    chk("rr_ready", ready, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      nx();
      chk($sformatf("rr_norsp%0d", i), rsp_valid, 0);
    end

    // back-to-back writes with cmd_valid held
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0201; cmd_dat = 32'h11223344;
    nx();
    chk("bb_sel", gsel, 0);
    chk("bb_busy", ready, 0);
    n = 0;
    while (gsel == 1'b0 && n < 20) begin nx(); n++; end
    chk("bb_len", n, 6);
    n = 0;
    while (gsel == 1'b1 && n < 20) begin n++; nx(); end
    chk("bb_gap", n, 2);
    cmd_valid = 0;
    chk("bb_gad", gad, 8'h02);
    repeat (6) nx();
    chk("bb_rspv", rsp_valid, 1);
    nx();
    chk("bb_ready", ready, 1);

    // write data changes after capture
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 16'h0003; cmd_dat = 32'hA5A5A5A5;
    nx();
    cmd_valid = 0;
    nx();
    cmd_dat = 32'h0;
    nx();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cap_gad%0d", i), gad, 8'hA5);
      nx();
    end
    chk("cap_rspv", rsp_valid, 1);
    nx();

    // RD_WAIT=15 read on the second instance
    cmd_valid2 = 1; cmd_wr = 0; cmd_addr = 16'h0077;
    nx();
    cmd_valid2 = 0;
    chk("w15_gad", gad2, 8'h00);
    repeat (16) nx();
    chk("w15_oe", oe2, 0);
    chk("w15_sel", gsel2, 0);
    nx(); gad_i2 = 8'hAA;
    nx(); gad_i2 = 8'hBB;
    nx(); gad_i2 = 8'hCC;
    nx(); gad_i2 = 8'hDD;
    chk("w15_rspv_early", rsp_valid2, 0);
    nx(); gad_i2 = 8'h00;
    chk("w15_rspv", rsp_valid2, 1);
    chk("w15_rspd", rsp_dat2, 32'hAABBCCDD);
    chk("w15_gap_sel", gsel2, 1);
    nx();
    chk("w15_ready", ready2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
